// File: rtl/acl_spi_reader.sv
// acl_spi_reader: mode-0 SPI master that enables the accelerometer and periodically reads one axis as a 10-bit tilt sample.
// Define ACL_AVG_EN to publish the average of every four samples instead of each sample.
module acl_spi_reader #(
    parameter int         CLK_DIV       = 50,
    parameter int         SAMPLE_PERIOD = 100000,
    parameter logic [7:0] AXIS_ADDR     = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic [9:0] acl_out,
    output logic       acl_valid
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int WW = $clog2(SAMPLE_PERIOD + 1);
    typedef enum logic [1:0] {INIT, WAIT, XFER, DONE} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [6:0] half;
    logic [6:0] nxt;
    logic [6:0] last;
    logic [5:0] bit_idx;
    logic [WW-1:0] wcnt;
    logic [31:0] tx;
    logic [9:0] rx;
    logic [9:0] sample;
    logic rd;
    logic keep;
    // half-periods: 0 setup, 2k+1 bit k low, 2k+2 bit k high, last = tail
    assign nxt = half + 7'd1;
    assign last = rd ? 7'd65 : 7'd49;
    assign bit_idx = half[6:1];
    // only L[7:2] and H[3:0] are kept, so rx ends as {L[7:2], H[3:0]}
    assign keep = (bit_idx >= 6'd16 && bit_idx <= 6'd21) || bit_idx >= 6'd28;
    assign sample = {rx[3:0], rx[9:4]};
`ifdef ACL_AVG_EN
    logic [11:0] acc;
    logic [11:0] sum;
    logic [1:0] navg;
    assign sum = acc + {{2{sample[9]}}, sample};
`endif
    always_ff @(posedge clk) begin
        acl_valid <= 1'b0;
        if (rst) begin
            state    <= INIT;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            acl_out  <= '0;
            div      <= '0;
            half     <= '0;
            wcnt     <= '0;
            tx       <= '0;
            rx       <= '0;
            rd       <= 1'b0;
`ifdef ACL_AVG_EN
            acc      <= '0;
            navg     <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
                    spi_cs_n <= 1'b0;
                    div      <= '0;
                    half     <= '0;
                    rd       <= 1'b0;
                    tx       <= {24'h0A2D02, 8'h00};
                    state    <= XFER;
                end
                WAIT: begin
                    if (wcnt == WW'(SAMPLE_PERIOD)) begin
                        spi_cs_n <= 1'b0;
                        div      <= '0;
                        half     <= '0;
                        rd       <= 1'b1;
                        tx       <= {8'h0B, AXIS_ADDR, 16'h0000};
                        state    <= XFER;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                XFER: begin
                    if (div != DW'(CLK_DIV - 1)) begin
                        div <= div + 1'b1;
                    end else begin
                        div  <= '0;
                        half <= nxt;
                        if (half == last) begin
                            spi_cs_n <= 1'b1;
                            spi_sclk <= 1'b0;
                            spi_mosi <= 1'b0;
                            wcnt     <= '0;
                            state    <= DONE;
                            if (rd) begin
`ifdef ACL_AVG_EN
                                navg <= navg + 1'b1;
                                if (navg == 2'd3) begin
                                    acl_out   <= sum[11:2];
                                    acl_valid <= 1'b1;
                                    acc       <= '0;
                                end else begin
                                    acc <= sum;
                                end
`else
                                acl_out   <= sample;
                                acl_valid <= 1'b1;
`endif
                            end
                        end else if (nxt == last) begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= 1'b0;
                        end else if (nxt[0]) begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx[31];
                            tx       <= {tx[30:0], 1'b0};
                        end else begin
                            spi_sclk <= 1'b1;
                            if (keep) rx <= {rx[8:0], spi_miso};
                        end
                    end
                end
                DONE: begin
                    wcnt  <= wcnt + 1'b1;
                    state <= WAIT;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
